msrv32_lsu: RTL and testbench
=============================

Name: msrv32_lsu

Overview:
- Load/store unit directly downstream of the integer ALU.
- Takes the ALU result as the effective address and runs one byte, half or word access on the data-memory bus over a req/ack handshake.
- Aligns store data into byte lanes with strobes, and extracts and extends load data for writeback.
- Flags misaligned or illegal accesses without touching the bus; a wait-state timeout turns a hung bus into an error.

Parameters:
- TIMEOUT_CYCLES, 255, maximum bus cycles with req high and no ack before the access ends in error; 0 disables the timeout; counter is 8 bits wide, legal range 0..255.

Ports:
- ms_riscv32_mp_clk_in  input  1  core clock, rising edge
- ms_riscv32_mp_rst_n_in  input  1  asynchronous active-low reset
- start_in  input  1  one-cycle request from core; sampled only in IDLE
- is_store_in  input  1  1 = store, 0 = load
- funct3_in  input  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- addr_in  input  32  effective address (ALU result)
- store_data_in  input  32  rs2 value
- busy_out  output  1  high while state is BUS or DONE
- done_out  output  1  one-cycle completion pulse
- load_data_out  output  32  extended load result
- misaligned_out  output  1  valid with done_out
- err_out  output  1  valid with done_out; illegal funct3, bus error or timeout
- dmem_req_out  output  1  bus request
- dmem_we_out  output  1  bus write enable
- dmem_addr_out  output  32  word address {addr[31:2],2'b00}
- dmem_wdata_out  output  32  lane-replicated store data
- dmem_wstrb_out  output  4  byte strobes; 0000 for loads
- dmem_ack_in  input  1  bus response
- dmem_rdata_in  input  32  read word, valid with ack
- dmem_err_in  input  1  bus error, valid with ack

Behaviour:
- Reset (async, active low): state IDLE; all outputs 0; counter 0. Applies mid-access too: req drops immediately, the access is abandoned, and no done_out is produced.
- States and transitions:
  - IDLE to DONE: on start_in when the access is illegal or misaligned.
  - IDLE to BUS: on start_in for a good access.
  - BUS to DONE: on ack or on timeout.
  - DONE to IDLE: always, after one cycle.
- Capture: on start_in in IDLE, latch is_store, funct3, addr and store_data. start_in in BUS or DONE is ignored.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: any funct3 other than 000, 001, 010.
- Misaligned:
  - Half accesses with addr[0]=1.
  - Word accesses with addr[1:0] != 00.
  - Illegal takes priority: err_out=1 with misaligned_out=0.
- Rejected accesses: dmem_req_out never asserts; DONE one cycle after start; load_data_out unchanged.
- Bus signalling: from the cycle after start, dmem_req_out=1 and addr/we/wdata/wstrb are registered and held stable until ack.
- Store lanes, with off=addr[1:0]:
  - SB: wstrb = 0001<<off, wdata = {4{byte}}.
  - SH: wstrb = 0011<<off, wdata = {2{half}}.
  - SW: wstrb = 1111, wdata = word.
- Ack in BUS:
  - req falls in the next cycle and the state moves to DONE.
  - err_out = dmem_err_in.
  - On a load without error, load_data_out = (rdata >> 8*off) truncated to byte/half, sign-extended for LB/LH and zero-extended for LBU/LHU; LW passes the word.
- Timeout: counter increments each BUS cycle without ack. When it reaches TIMEOUT_CYCLES, go DONE with err_out=1 and req drops. An ack in that same cycle wins (normal completion).
- DONE: done_out=1 for exactly one cycle. misaligned_out and err_out are valid that cycle and are 0 otherwise.
- load_data_out holds its value until the next successful load; it is never changed by stores or errors.
- Ack in IDLE or DONE is ignored.
- Latency: start at cycle N, req at N+1, earliest ack N+1, done at N+2. The next start is accepted at N+3.

Test Plan:
- LB addr=0x1003, rdata=0x80FFFFFF, ack after 0 waits -> req high 1 cycle, wstrb=0000, done 2 cycles after start, load_data_out=0xFFFFFF80; repeat as LBU -> 0x00000080.
- SH addr=0x2002, store_data=0x0000BEEF, ack after 3 waits -> dmem_addr_out=0x2000, wstrb=1100, wdata=0xBEEFBEEF held 4 cycles, done_out pulse, err_out=0.
- LW addr=0x3001 -> no req ever, done_out one cycle after start, misaligned_out=1, err_out=0; store with funct3=011 -> err_out=1, misaligned_out=0.
- TIMEOUT_CYCLES=4, LW addr=0x4000, ack never -> req high exactly 4 cycles, then done_out with err_out=1; load_data_out keeps its previous value.
- LW with ack and dmem_err_in=1 -> err_out=1, load_data_out unchanged; start_in pulsed during BUS is ignored (exactly one access).
- Reset asserted during BUS wait -> req drops asynchronously, no done_out; start after reset release behaves normally.

Source files
------------

// File: rtl/msrv32_lsu.sv
// Load/store unit: one byte/half/word access per request over a req/ack data bus,
// with store lane steering, load extraction/extension, alignment checks and a wait-state timeout.
module msrv32_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic        start_in,
  input  logic        is_store_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic        busy_out,
  output logic        done_out,
  output logic [31:0] load_data_out,
  output logic        misaligned_out,
  output logic        err_out,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_wstrb_out,
  input  logic        dmem_ack_in,
  input  logic [31:0] dmem_rdata_in,
  input  logic        dmem_err_in
);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  typedef struct packed {
    logic       is_store;
    logic [2:0] funct3;
    logic [1:0] off;
  } acc_t;

  localparam logic       TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  acc_t        acc;
  logic [7:0]  wait_cnt;
  logic        illegal, misaligned, timeout_hit;
  logic [3:0]  wstrb;
  logic [31:0] wdata, shifted, ld_ext;

  always_comb begin
    if (is_store_in) illegal = funct3_in[2] || (funct3_in[1:0] == 2'b11);
    else             illegal = (funct3_in == 3'b011) || (funct3_in[2:1] == 2'b11);
    misaligned = !illegal &&
                 (((funct3_in[1:0] == 2'b01) && addr_in[0]) ||
                  ((funct3_in[1:0] == 2'b10) && (addr_in[1:0] != 2'b00)));
  end

  // Data is replicated across lanes so the bus can pick it up at any offset.
  always_comb begin
    wstrb = 4'b1111;
    wdata = store_data_in;
    case (funct3_in[1:0])
      2'b00: begin
        wstrb = 4'b0001 << addr_in[1:0];
        wdata = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        wstrb = 4'b0011 << addr_in[1:0];
        wdata = {2{store_data_in[15:0]}};
      end
      default: ;
    endcase
    if (!is_store_in) wstrb = 4'b0000;
  end

  assign shifted = dmem_rdata_in >> {acc.off, 3'b000};

  always_comb begin
    case (acc.funct3)
      3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_ext = {24'd0, shifted[7:0]};
      3'b101:  ld_ext = {16'd0, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

  assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state          <= IDLE;
      acc            <= '0;
      wait_cnt       <= '0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      misaligned_out <= 1'b0;
      err_out        <= 1'b0;
      load_data_out  <= '0;
      dmem_req_out   <= 1'b0;
      dmem_we_out    <= 1'b0;
      dmem_addr_out  <= '0;
      dmem_wdata_out <= '0;
      dmem_wstrb_out <= '0;
    end else begin
      done_out       <= 1'b0;
      err_out        <= 1'b0;
      misaligned_out <= 1'b0;
      case (state)
        IDLE: if (start_in) begin
          acc      <= '{is_store: is_store_in, funct3: funct3_in, off: addr_in[1:0]};
          busy_out <= 1'b1;
          if (illegal || misaligned) begin
            state          <= DONE;
            done_out       <= 1'b1;
            err_out        <= illegal;
            misaligned_out <= misaligned;
          end else begin
            state          <= BUS;
            wait_cnt       <= '0;
            dmem_req_out   <= 1'b1;
            dmem_we_out    <= is_store_in;
            dmem_addr_out  <= {addr_in[31:2], 2'b00};
            dmem_wdata_out <= wdata;
            dmem_wstrb_out <= wstrb;
          end
        end
        // An ack in the timeout cycle still completes normally.
        BUS: if (dmem_ack_in || timeout_hit) begin
          state          <= DONE;
          done_out       <= 1'b1;
          err_out        <= dmem_ack_in ? dmem_err_in : 1'b1;
          dmem_req_out   <= 1'b0;
          dmem_we_out    <= 1'b0;
          dmem_wstrb_out <= 4'b0000;
          if (dmem_ack_in && !acc.is_store && !dmem_err_in) load_data_out <= ld_ext;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
        DONE: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_msrv32_lsu.sv
// Bench for msrv32_lsu: directed scenarios plus randomized accesses against a byte-level model.
module tb_msrv32_lsu;
  localparam int TO = 4;

  logic clk = 1'b0, rst_n;
  logic start_in, is_store_in, dmem_ack_in, dmem_err_in;
  logic [2:0] funct3_in;
  logic [31:0] addr_in, store_data_in, dmem_rdata_in;
  logic busy_out, done_out, misaligned_out, err_out, dmem_req_out, dmem_we_out;
  logic [31:0] load_data_out, dmem_addr_out, dmem_wdata_out;
  logic [3:0] dmem_wstrb_out;

  msrv32_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n),
    .start_in(start_in), .is_store_in(is_store_in), .funct3_in(funct3_in),
    .addr_in(addr_in), .store_data_in(store_data_in),
    .busy_out(busy_out), .done_out(done_out), .load_data_out(load_data_out),
    .misaligned_out(misaligned_out), .err_out(err_out),
    .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out), .dmem_addr_out(dmem_addr_out),
    .dmem_wdata_out(dmem_wdata_out), .dmem_wstrb_out(dmem_wstrb_out),
    .dmem_ack_in(dmem_ack_in), .dmem_rdata_in(dmem_rdata_in), .dmem_err_in(dmem_err_in));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  logic [31:0] ld_model;

  // observations from one access
  int obs_req, obs_done_at, obs_done_cnt;
  logic obs_err, obs_mis, obs_we;
  logic [31:0] obs_ld, obs_addr, obs_wdata;
  logic [3:0] obs_strb;
  bit obs_stable, obs_spurious;

  // model expectations
  bit exp_rej;
  logic exp_err, exp_mis;
  int exp_req, exp_done;
  logic [3:0] exp_strb;
  logic [31:0] exp_wd;

  task automatic predict(input logic st, input logic [2:0] f3, input logic [31:0] a, sd, rd,
                         input int waits, input logic be);
    int nb, off;
    bit legal;
    logic [63:0] v;
    nb = 1 << f3[1:0];
    off = int'(a % 4);
    legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    exp_mis = legal && ((a % nb) != 0);
    exp_rej = !legal || exp_mis;
    exp_err = !legal;
    exp_strb = '0;
    exp_wd = '0;
    if (st && legal) begin
      exp_strb = 4'(((1 << nb) - 1) << off);
      for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = sd[8*(i % nb) +: 8];
    end
    if (exp_rej) begin
      exp_req = 0; exp_done = 1;
    end else if (waits >= 0 && waits < TO) begin
      exp_req = waits + 1; exp_done = waits + 2; exp_err = be;
      if (!st && !be) begin
        v = {32'd0, rd} >> (8 * off);
        if (nb < 4) begin
          v = v & ((64'd1 << (8 * nb)) - 64'd1);
          if (!f3[2] && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
        end
        ld_model = v[31:0];
      end
    end else begin
      exp_req = TO; exp_done = TO + 1; exp_err = 1'b1;
    end
  endtask

  // Drives one access, acts as the bus slave, and records what the DUT did over 12 cycles.
  task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a, sd,
                            input int waits, input logic [31:0] rd, input logic be, input bit poke);
    obs_req = 0; obs_done_at = -1; obs_done_cnt = 0; obs_err = 0; obs_mis = 0; obs_we = 0;
    obs_ld = '0; obs_addr = '0; obs_wdata = '0; obs_strb = '0; obs_stable = 1; obs_spurious = 0;
    start_in = 1; is_store_in = st; funct3_in = f3; addr_in = a; store_data_in = sd;
    @(posedge clk); #1;
    start_in = 0; is_store_in = 1'($urandom); funct3_in = 3'($urandom);
    addr_in = $urandom; store_data_in = $urandom;
    for (int c = 1; c <= 12; c++) begin
      if (dmem_req_out) begin
        if (obs_req == 0) begin
          obs_addr = dmem_addr_out; obs_wdata = dmem_wdata_out;
          obs_strb = dmem_wstrb_out; obs_we = dmem_we_out;
        end else if ({obs_addr, obs_wdata, obs_strb, obs_we} !==
                     {dmem_addr_out, dmem_wdata_out, dmem_wstrb_out, dmem_we_out}) begin
          obs_stable = 0;
        end
        if (waits >= 0 && obs_req == waits) begin
          dmem_ack_in = 1; dmem_rdata_in = rd; dmem_err_in = be;
        end
        obs_req++;
      end else begin
        dmem_ack_in = 1'($urandom);
      end
      if (done_out) begin
        obs_done_cnt++;
        if (obs_done_at < 0) begin
          obs_done_at = c; obs_err = err_out; obs_mis = misaligned_out; obs_ld = load_data_out;
        end
      end else if (err_out || misaligned_out) begin
        obs_spurious = 1;
      end
      if (poke && c == 1) start_in = 1;
      @(posedge clk); #1;
      dmem_ack_in = 0; start_in = 0; dmem_rdata_in = $urandom; dmem_err_in = 1'($urandom);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; start_in = 0; is_store_in = 0; funct3_in = 0; addr_in = 0; store_data_in = 0;
    dmem_ack_in = 0; dmem_rdata_in = 0; dmem_err_in = 0;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (dmem_req_out !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", dmem_req_out); end
    n_checks++; if ({busy_out, done_out} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done got %b want 00", {busy_out, done_out}); end
    n_checks++; if (load_data_out !== 32'd0) begin n_fail++; $display("FAIL reset_ld got %h want 0", load_data_out); end
    n_checks++; if ({err_out, misaligned_out, dmem_we_out, dmem_wstrb_out, dmem_addr_out, dmem_wdata_out} !== '0) begin
      n_fail++; $display("FAIL reset_bus got %b%b%b %h %h %h want zeros", err_out, misaligned_out, dmem_we_out, dmem_wstrb_out, dmem_addr_out, dmem_wdata_out);
    end
    rst_n = 1;
    ld_model = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_byte();
    predict(0, 3'b000, 32'h1003, 0, 32'h80FFFFFF, 0, 0);
    run_access(0, 3'b000, 32'h1003, 0, 0, 32'h80FFFFFF, 0, 0);
    n_checks++; if (obs_req !== 1) begin n_fail++; $display("FAIL lb_req_cycles got %0d want 1", obs_req); end
    n_checks++; if (obs_strb !== 4'b0000) begin n_fail++; $display("FAIL lb_wstrb got %b want 0000", obs_strb); end
    n_checks++; if (obs_done_at !== 2) begin n_fail++; $display("FAIL lb_done_at got %0d want 2", obs_done_at); end
    n_checks++; if (obs_ld !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_data got %h want ffffff80", obs_ld); end
    predict(0, 3'b100, 32'h1003, 0, 32'h80FFFFFF, 0, 0);
    run_access(0, 3'b100, 32'h1003, 0, 0, 32'h80FFFFFF, 0, 0);
    n_checks++; if (obs_ld !== 32'h00000080) begin n_fail++; $display("FAIL lbu_data got %h want 00000080", obs_ld); end
  endtask

  task automatic test_store_half();
    predict(1, 3'b001, 32'h2002, 32'h0000BEEF, 0, 3, 0);
    run_access(1, 3'b001, 32'h2002, 32'h0000BEEF, 3, $urandom, 0, 0);
    n_checks++; if (obs_addr !== 32'h2000) begin n_fail++; $display("FAIL sh_addr got %h want 00002000", obs_addr); end
    n_checks++; if (obs_strb !== 4'b1100) begin n_fail++; $display("FAIL sh_wstrb got %b want 1100", obs_strb); end
    n_checks++; if (obs_wdata !== 32'hBEEFBEEF) begin n_fail++; $display("FAIL sh_wdata got %h want beefbeef", obs_wdata); end
    n_checks++; if (obs_req !== 4 || !obs_stable) begin n_fail++; $display("FAIL sh_hold got %0d/%0d want 4/1", obs_req, obs_stable); end
    n_checks++; if (obs_done_cnt !== 1 || obs_err !== 1'b0) begin n_fail++; $display("FAIL sh_done got cnt %0d err %b want 1 0", obs_done_cnt, obs_err); end
    n_checks++; if (obs_ld !== 32'h00000080) begin n_fail++; $display("FAIL sh_ld_kept got %h want 00000080", obs_ld); end
  endtask

  task automatic test_rejects();
    run_access(0, 3'b010, 32'h3001, 0, 0, $urandom, 0, 0);
    n_checks++; if (obs_req !== 0 || obs_done_at !== 1) begin n_fail++; $display("FAIL lw_mis_timing got req %0d done %0d want 0 1", obs_req, obs_done_at); end
    n_checks++; if ({obs_mis, obs_err} !== 2'b10) begin n_fail++; $display("FAIL lw_mis_flags got %b want 10", {obs_mis, obs_err}); end
    run_access(1, 3'b011, 32'h3000, $urandom, 0, $urandom, 0, 0);
    n_checks++; if ({obs_mis, obs_err} !== 2'b01 || obs_req !== 0) begin n_fail++; $display("FAIL st_illegal got flags %b req %0d want 01 0", {obs_mis, obs_err}, obs_req); end
    n_checks++; if (obs_ld !== 32'h00000080) begin n_fail++; $display("FAIL reject_ld got %h want 00000080", obs_ld); end
  endtask

  task automatic test_timeout();
    run_access(0, 3'b010, 32'h4000, 0, -1, 0, 0, 0);
    n_checks++; if (obs_req !== 4) begin n_fail++; $display("FAIL to_req_cycles got %0d want 4", obs_req); end
    n_checks++; if (obs_done_at !== 5 || obs_err !== 1'b1) begin n_fail++; $display("FAIL to_done got at %0d err %b want 5 1", obs_done_at, obs_err); end
    n_checks++; if (obs_ld !== 32'h00000080) begin n_fail++; $display("FAIL to_ld_kept got %h want 00000080", obs_ld); end
  endtask

  task automatic test_bus_err();
    run_access(0, 3'b010, 32'h7000, 0, 1, 32'h12345678, 1, 1);
    n_checks++; if (obs_err !== 1'b1 || obs_done_at !== 3) begin n_fail++; $display("FAIL berr_done got err %b at %0d want 1 3", obs_err, obs_done_at); end
    n_checks++; if (obs_ld !== 32'h00000080) begin n_fail++; $display("FAIL berr_ld_kept got %h want 00000080", obs_ld); end
    n_checks++; if (obs_done_cnt !== 1 || obs_req !== 2) begin n_fail++; $display("FAIL berr_single got dones %0d req %0d want 1 2", obs_done_cnt, obs_req); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic st, be;
      logic [2:0] f3;
      logic [31:0] a, sd, rd;
      int waits;
      bit poke;
      st = 1'($urandom); f3 = 3'($urandom); a = $urandom; sd = $urandom; rd = $urandom;
      waits = $urandom_range(0, 4); if (waits == 4) waits = -1;
      be = ($urandom_range(0, 7) == 0); poke = 1'($urandom);
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      predict(st, f3, a, sd, rd, waits, be);
      run_access(st, f3, a, sd, waits, rd, be, poke);
      n_checks++; if (obs_done_cnt !== 1 || obs_done_at !== exp_done) begin n_fail++; $display("FAIL rnd%0d_done got %0d@%0d want 1@%0d", n, obs_done_cnt, obs_done_at, exp_done); end
      n_checks++; if (obs_req !== exp_req) begin n_fail++; $display("FAIL rnd%0d_req got %0d want %0d", n, obs_req, exp_req); end
      n_checks++; if ({obs_err, obs_mis} !== {exp_err, exp_mis} || obs_spurious) begin n_fail++; $display("FAIL rnd%0d_flags got %b%b sp %0d want %b%b", n, obs_err, obs_mis, obs_spurious, exp_err, exp_mis); end
      n_checks++; if (obs_ld !== ld_model) begin n_fail++; $display("FAIL rnd%0d_ld got %h want %h", n, obs_ld, ld_model); end
      if (!exp_rej) begin
        n_checks++; if (obs_addr !== {a[31:2], 2'b00} || obs_we !== st || !obs_stable) begin n_fail++; $display("FAIL rnd%0d_bus got %h we %b stable %0d want %h %b", n, obs_addr, obs_we, obs_stable, {a[31:2], 2'b00}, st); end
        n_checks++; if (obs_strb !== exp_strb) begin n_fail++; $display("FAIL rnd%0d_wstrb got %b want %b", n, obs_strb, exp_strb); end
        if (st) begin
          n_checks++; if (obs_wdata !== exp_wd) begin n_fail++; $display("FAIL rnd%0d_wdata got %h want %h", n, obs_wdata, exp_wd); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    start_in = 1; is_store_in = 0; funct3_in = 3'b010; addr_in = 32'h5000;
    @(posedge clk); #1;
    start_in = 0;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    n_checks++; if (dmem_req_out !== 1'b0 || busy_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async got req %b busy %b want 0 0", dmem_req_out, busy_out); end
    @(posedge clk); #1;
    n_checks++; if (done_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got %b want 0", done_out); end
    rst_n = 1;
    ld_model = '0;
    predict(0, 3'b101, 32'h6006, 0, 32'hA5C3_0000, 1, 0);
    run_access(0, 3'b101, 32'h6006, 0, 1, 32'hA5C3_0000, 0, 0);
    n_checks++; if (obs_ld !== 32'h0000A5C3 || obs_done_at !== 3) begin n_fail++; $display("FAIL rst_mid_after got %h@%0d want 0000a5c3@3", obs_ld, obs_done_at); end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_rejects();
    test_timeout();
    test_bus_err();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
